a2d_intf: RTL and testbench



---
 rtl/a2d_pkg.sv | 30 +++
 rtl/a2d_intf_spi_mstr16.sv | 78 +++++++
 rtl/a2d_intf.sv | 130 +++++++++++++
 tb/tb_a2d_intf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// ---------------------------------------------------------------------------
// a2d_pkg : shared types, SPI timing constants and channel-select word builder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package a2d_pkg;

  localparam int FRAME_W = 16;

  localparam logic [4:0] SCLK_LOAD = 5'b10111;
  localparam logic [4:0] SCLK_RISE = 5'd15;
  localparam logic [4:0] SCLK_FALL = 5'd31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRAME1 = 3'd1,
    GAP    = 3'd2,
    FRAME2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Channel sits in bits [13:11] of the control word; all other bits zero.
  function automatic logic [FRAME_W-1:0] tx_word(input logic [2:0] chnnl);
    return {2'b00, chnnl, 11'h000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_intf_spi_mstr16.sv
// ---------------------------------------------------------------------------
// spi_mstr16 : one full-duplex SPI frame (SCLK idles high, MOSI on fall, MISO on rise)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_mstr16 #(
  parameter int SCLK_DIV_W = 5,
  parameter int FRAME_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               miso,
  output logic               done,
  output logic [FRAME_W-1:0] rx_data,
  output logic               ss_n,
  output logic               sclk,
  output logic               mosi
);

  import a2d_pkg::*;

  localparam int CNT_W = $clog2(FRAME_W + 1);

  localparam logic [SCLK_DIV_W-1:0] c_load  = SCLK_DIV_W'(SCLK_LOAD);
  localparam logic [SCLK_DIV_W-1:0] c_rise  = SCLK_DIV_W'(SCLK_RISE);
  localparam logic [SCLK_DIV_W-1:0] c_fall  = SCLK_DIV_W'(SCLK_FALL);
  localparam logic [CNT_W-1:0]      c_frame = CNT_W'(FRAME_W);

  logic [SCLK_DIV_W-1:0] r_div;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_W-1:0]    r_shreg;
  logic                  r_ss_n;
  logic                  r_mosi;
  logic                  w_last;

  // Last clk of the frame: every bit sampled and SCLK back at its high end.
  assign w_last = !r_ss_n && (r_cnt == c_frame) && (r_div == c_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_n  <= 1'b1;
      r_div   <= '0;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_mosi  <= 1'b0;
    end else if (r_ss_n) begin
      if (wrt) begin
        r_ss_n  <= 1'b0;
        r_div   <= c_load;
        r_cnt   <= '0;
        r_shreg <= tx_data;
      end
    end else if (w_last) begin
      r_ss_n <= 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
      if (r_div == c_fall) begin
        r_mosi <= r_shreg[FRAME_W-1];
      end
      if (r_div == c_rise) begin
        r_shreg <= {r_shreg[FRAME_W-2:0], miso};
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign done    = w_last;
  assign rx_data = r_shreg;
  assign ss_n    = r_ss_n;
  assign sclk    = r_ss_n | r_div[SCLK_DIV_W-1];
  assign mosi    = r_mosi;

endmodule

`default_nettype wire

// File: rtl/a2d_intf.sv
// ---------------------------------------------------------------------------
// a2d_intf : channel-select + readback SPI sequencer for the 8-ch 12-bit A2D.
// Optional build macro A2D_RES_INV_EN inverts the published result.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module a2d_intf #(
  parameter int SCLK_DIV_W = 5,
  parameter int FRAME_W    = a2d_pkg::FRAME_W,
  parameter int GAP_CLKS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] res,
  output logic        cnv_cmplt
);

  import a2d_pkg::*;

  // The GAP state lasts GAP_CLKS-1 cycles; the registered wrt adds the last one.
  localparam int GAP_W = (GAP_CLKS > 2) ? $clog2(GAP_CLKS - 1) : 1;
  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(GAP_CLKS - 2);

  state_t             r_state, w_state_nxt;
  logic               r_wrt, w_wrt_nxt;
  logic [FRAME_W-1:0] r_tx, w_tx_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [11:0]        r_res, w_res_nxt;
  logic               r_cmplt, w_cmplt_nxt;

  logic               w_spi_done;
  logic [FRAME_W-1:0] w_rx;
  logic [11:0]        w_res_new;
  logic               w_unused_rx;

  spi_mstr16 #(
    .SCLK_DIV_W (SCLK_DIV_W),
    .FRAME_W    (FRAME_W)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (r_wrt),
    .tx_data (r_tx),
    .miso    (MISO),
    .done    (w_spi_done),
    .rx_data (w_rx),
    .ss_n    (SS_n),
    .sclk    (SCLK),
    .mosi    (MOSI)
  );

  assign w_unused_rx = ^w_rx[FRAME_W-1:12];

`ifdef A2D_RES_INV_EN
  assign w_res_new = ~w_rx[11:0];
`else
  assign w_res_new = w_rx[11:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wrt   <= 1'b0;
      r_tx    <= '0;
      r_gap   <= '0;
      r_res   <= '0;
      r_cmplt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrt   <= w_wrt_nxt;
      r_tx    <= w_tx_nxt;
      r_gap   <= w_gap_nxt;
      r_res   <= w_res_nxt;
      r_cmplt <= w_cmplt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrt_nxt   = 1'b0;
    w_tx_nxt    = r_tx;
    w_gap_nxt   = r_gap;
    w_res_nxt   = r_res;
    w_cmplt_nxt = r_cmplt;
    case (r_state)
      IDLE, DONE: begin
        if (strt_cnv) begin
          w_state_nxt = FRAME1;
          w_wrt_nxt   = 1'b1;
          w_tx_nxt    = FRAME_W'(tx_word(chnnl));
          w_cmplt_nxt = 1'b0;
        end
      end
      FRAME1: begin
        if (w_spi_done) begin
          w_state_nxt = GAP;
          w_gap_nxt   = c_gap_load;
        end
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = FRAME2;
          w_wrt_nxt   = 1'b1;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      FRAME2: begin
        if (w_spi_done) begin
          w_state_nxt = DONE;
          w_res_nxt   = w_res_new;
          w_cmplt_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign res       = r_res;
  assign cnv_cmplt = r_cmplt;

endmodule

`default_nettype wire

// File: tb/tb_a2d_intf.sv
// ---------------------------------------------------------------------------
// tb_a2d_intf : directed bench for a2d_intf with an A2D slave model on the SPI pins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO = 1'b0;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] res;
  logic        cnv_cmplt;

  int errors = 0;
  int checks = 0;

  a2d_intf dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .res       (res),
    .cnv_cmplt (cnv_cmplt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_res_of(input logic [15:0] w2);
    logic [11:0] r;
    r = w2[11:0];
`ifdef A2D_RES_INV_EN
    r = ~r;
`endif
    return r;
  endfunction

  // ---------------- A2D slave model / pin monitor ----------------
  logic [15:0] miso_word2 = 16'h0000;
  logic [15:0] miso_cur   = 16'h0000;
  logic [15:0] mosi_sh    = 16'h0000;
  int          cnv_id     = 0;
  int          mon_id     = 0;
  int          frm        = 0;
  int          fcnt       = 0;
  int          total_falls = 0;
  logic [15:0] mosi_w [2];
  int          falls_w [2];
  longint      fall_t [2];
  longint      rise_t [2];
  longint      per_w      = 0;
  longint      last_fall_t = 0;
  logic        ss_q = 1'b1;
  logic        sclk_q = 1'b1;

  always @(SS_n or SCLK) begin
    if (ss_q === 1'b1 && SS_n === 1'b0) begin
      if (mon_id != cnv_id) begin
        mon_id = cnv_id;
        frm    = 0;
        for (int i = 0; i < 2; i++) begin
          mosi_w[i]  = '0;
          falls_w[i] = 0;
          fall_t[i]  = 0;
          rise_t[i]  = 0;
        end
        per_w = 0;
      end
      frm++;
      fcnt     = 0;
      mosi_sh  = '0;
      miso_cur = (frm == 1) ? 16'hFFFF : miso_word2;
      if (frm <= 2) fall_t[frm-1] = $time;
    end
    if (ss_q === 1'b0 && SS_n === 1'b1) begin
      if (frm >= 1 && frm <= 2) begin
        mosi_w[frm-1] = mosi_sh;
        rise_t[frm-1] = $time;
      end
    end
    if (sclk_q === 1'b1 && SCLK === 1'b0 && SS_n === 1'b0) begin
      total_falls++;
      if (frm >= 1 && frm <= 2) falls_w[frm-1]++;
      if (fcnt > 0) per_w = $time - last_fall_t;
      last_fall_t = $time;
      if (fcnt < 16) MISO = miso_cur[15-fcnt];
      fcnt++;
    end
    if (sclk_q === 1'b0 && SCLK === 1'b1 && SS_n === 1'b0) begin
      mosi_sh = {mosi_sh[14:0], MOSI};
    end
    ss_q   = SS_n;
    sclk_q = SCLK;
  end

  // One full conversion; strt_cnv sampled at edge 0, optional busy poke at edge 'poke'.
  task automatic run_cnv(input logic [2:0] ch, input logic [15:0] w2, input int poke,
                         input logic [11:0] old_res);
    int          lat = -1;
    logic [15:0] exp_tx;
    exp_tx     = {2'b00, ch, 11'h000};
    miso_word2 = w2;
    cnv_id++;
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    chnnl    = ~ch;
    check_val("cmplt_drop", 32'(cnv_cmplt), 0);
    check_val("res_hold_start", 32'(res), 32'(old_res));
    for (int n = 1; n <= 1100 && lat < 0; n++) begin
      if (n == poke) begin
        strt_cnv = 1'b1;
        chnnl    = 3'd2;
      end else begin
        strt_cnv = 1'b0;
      end
      @(posedge clk);
      #1;
      if (n == 1044) begin
        check_val("res_hold_1044", 32'(res), 32'(old_res));
        check_val("cmplt_1044", 32'(cnv_cmplt), 0);
      end
      if (cnv_cmplt === 1'b1) lat = n;
    end
    strt_cnv = 1'b0;
    check_val("latency", lat, 1045);
    check_val("res", 32'(res), 32'(exp_res_of(w2)));
    check_val("frames", frm, 2);
    check_val("mosi_f1", 32'(mosi_w[0]), 32'(exp_tx));
    check_val("mosi_f2", 32'(mosi_w[1]), 32'(exp_tx));
    check_val("falls_f1", falls_w[0], 16);
    check_val("falls_f2", falls_w[1], 16);
    check_val("ss_low_f1", 32'((rise_t[0] - fall_t[0]) / 10), 521);
    check_val("ss_low_f2", 32'((rise_t[1] - fall_t[1]) / 10), 521);
    check_val("gap", 32'((fall_t[1] - rise_t[0]) / 10), 2);
    check_val("sclk_per", 32'(per_w / 10), 32);
  endtask

  initial begin
    logic [11:0] prev;
    logic [15:0] w2;
    int          falls_before;

    rst      = 1'b1;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ss_n", 32'(SS_n), 1);
    check_val("rst_sclk", 32'(SCLK), 1);
    check_val("rst_mosi", 32'(MOSI), 0);
    check_val("rst_res", 32'(res), 0);
    check_val("rst_cmplt", 32'(cnv_cmplt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Channel 5 with a busy-time request for channel 2 at edge 600.
    run_cnv(3'd5, 16'h0ABC, 600, 12'h000);
    prev = exp_res_of(16'h0ABC);

    // Back-to-back: request on the clk right after cnv_cmplt rose.
    run_cnv(3'd3, 16'h0123, 0, prev);

    // Reset in the middle of frame 1.
    cnv_id++;
    miso_word2 = 16'h0555;
    @(negedge clk);
    strt_cnv = 1'b1;
    chnnl    = 3'd6;
    @(posedge clk);
    #1;
    strt_cnv = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_ss_n", 32'(SS_n), 1);
    check_val("midrst_sclk", 32'(SCLK), 1);
    check_val("midrst_mosi", 32'(MOSI), 0);
    check_val("midrst_cmplt", 32'(cnv_cmplt), 0);
    check_val("midrst_res", 32'(res), 0);
    falls_before = total_falls;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_val("midrst_no_sclk", total_falls, falls_before);
    check_val("midrst_ss_idle", 32'(SS_n), 1);
    check_val("midrst_res_idle", 32'(res), 0);

    // motion_cntrl-style sweep over all channels.
    prev = 12'h000;
    for (int ch = 0; ch < 8; ch++) begin
      w2 = {4'h0, 3'(ch), 9'h0A5};
      run_cnv(3'(ch), w2, 0, prev);
      prev = exp_res_of(w2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
